// File: rtl/eth_mac_tx_fcs_ctrl_pkg.sv
// Shared MAC TX definitions: sequencer state encoding, framing constants and
// the reflected CRC-32 byte update used by the FCS engine.
package eth_mac_tx_fcs_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_PAD  = 3'd2,
        ST_FCS  = 3'd3,
        ST_IFG  = 3'd4
    } tx_state_e;

    localparam int          FCS_BYTES   = 4;
    localparam int          ETH_MIN_LEN = 60;
    localparam logic [7:0]  PAD_BYTE    = 8'h00;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;

    // Ethernet CRC is LSB-first, so each input bit is folded in from bit 0 upward.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ data[i];
            c  = {1'b0, c[31:1]} ^ (fb ? CRC_POLY : 32'h0);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_mac_tx_fcs_ctrl_if.sv
// Byte-stream bus between TX buffer, FCS sequencer and PHY.
// slave is the sequencer's view; master is the environment driving it.
interface eth_mac_tx_fcs_ctrl_if;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tready;
    logic       s_tlast;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic       m_tlast;

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast
    );

    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/eth_mac_crc32.sv
// Byte-wide Ethernet CRC-32 engine; crc_out is the complemented register,
// ready to transmit low byte first.
module eth_mac_crc32
    import eth_mac_tx_fcs_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        crc_clear,
    input  logic        crc_en,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] crc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC_INIT;
        end else if (crc_clear) begin
            crc_q <= CRC_INIT;
        end else if (crc_en) begin
            crc_q <= crc32_byte(crc_q, data_in);
        end
    end

    assign crc_out = ~crc_q;

endmodule

// File: rtl/eth_mac_tx_fcs_ctrl.sv
// TX frame sequencer: payload pass-through, zero padding to MIN_LEN, FCS append
// and inter-frame gap.
//
// state   | meaning
// IDLE    | CRC held cleared, waiting for first payload byte to be offered
// DATA    | zero-latency payload pass-through, CRC accumulates s-side bytes
// PAD     | emitting PAD_BYTE until MIN_LEN bytes have been sent
// FCS     | emitting the frozen CRC, low byte first
// IFG     | idle gap of IFG_CYCLES cycles, CRC held cleared
module eth_mac_tx_fcs_ctrl
    import eth_mac_tx_fcs_ctrl_pkg::*;
#(
    parameter int MIN_LEN    = ETH_MIN_LEN,
    parameter int IFG_CYCLES = 12,
    parameter int CNT_W      = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    eth_mac_tx_fcs_ctrl_if.slave  bus,
    output logic                  busy,
    output logic                  pad_active,
    output logic                  frame_done
);

    localparam int               IFG_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [IFG_W-1:0] IFG_LOAD = IFG_W'(IFG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_LEN);
    localparam logic [1:0]       FCS_LAST = 2'(FCS_BYTES - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]       fcs_idx_q, fcs_idx_d;
    logic [IFG_W-1:0] ifg_q, ifg_d;

    logic        crc_clear;
    logic        crc_en;
    logic [7:0]  crc_din;
    logic [31:0] crc_out;
    logic [31:0] crc_sh;

    eth_mac_crc32 u_crc (
        .clk       (clk),
        .rst_n     (~rst),
        .crc_clear (crc_clear),
        .crc_en    (crc_en),
        .data_in   (crc_din),
        .crc_out   (crc_out)
    );

    // Saturating count keeps very long frames from wrapping back under MIN_LEN.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign crc_sh  = crc_out >> {fcs_idx_q, 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            fcs_idx_q <= '0;
            ifg_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fcs_idx_q <= fcs_idx_d;
            ifg_q     <= ifg_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fcs_idx_d    = fcs_idx_q;
        ifg_d        = ifg_q;
        bus.s_tready = 1'b0;
        bus.m_tdata  = PAD_BYTE;
        bus.m_tvalid = 1'b0;
        bus.m_tlast  = 1'b0;
        crc_clear    = 1'b0;
        crc_en       = 1'b0;
        crc_din      = PAD_BYTE;
        pad_active   = 1'b0;
        frame_done   = 1'b0;
        busy         = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                crc_clear = 1'b1;
                cnt_d     = '0;
                fcs_idx_d = '0;
                if (bus.s_tvalid) state_d = ST_DATA;
            end
            ST_DATA: begin
                bus.m_tdata  = bus.s_tdata;
                bus.m_tvalid = bus.s_tvalid;
                bus.s_tready = bus.m_tready;
                crc_din      = bus.s_tdata;
                if (bus.s_tvalid && bus.m_tready) begin
                    crc_en = 1'b1;
                    cnt_d  = cnt_inc;
                    if (bus.s_tlast) state_d = (cnt_inc < MIN_CNT) ? ST_PAD : ST_FCS;
                end
            end
            ST_PAD: begin
                bus.m_tvalid = 1'b1;
                pad_active   = 1'b1;
                if (bus.m_tready) begin
                    crc_en = 1'b1;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == MIN_CNT) state_d = ST_FCS;
                end
            end
            ST_FCS: begin
                bus.m_tvalid = 1'b1;
                bus.m_tdata  = crc_sh[7:0];
                bus.m_tlast  = (fcs_idx_q == FCS_LAST);
                if (bus.m_tready) begin
                    if (fcs_idx_q == FCS_LAST) begin
                        frame_done = 1'b1;
                        fcs_idx_d  = '0;
                        if (IFG_CYCLES == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_IFG;
                            ifg_d   = IFG_LOAD;
                        end
                    end else begin
                        fcs_idx_d = fcs_idx_q + 2'd1;
                    end
                end
            end
            ST_IFG: begin
                crc_clear = 1'b1;
                if (ifg_q == '0) state_d = ST_IDLE;
                else             ifg_d   = ifg_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_eth_mac_tx_fcs_ctrl.sv
// Scoreboard bench for the TX FCS sequencer: two instances (default MIN_LEN/IFG
// and MIN_LEN=1/IFG=0), expected byte streams built from a reference CRC-32.
module tb_eth_mac_tx_fcs_ctrl;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       pad;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    eth_mac_tx_fcs_ctrl_if bus0 ();
    eth_mac_tx_fcs_ctrl_if bus1 ();
    logic busy0, pad0, done0, busy1, pad1, done1;

    eth_mac_tx_fcs_ctrl #(.MIN_LEN(60), .IFG_CYCLES(12), .CNT_W(11)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave),
        .busy(busy0), .pad_active(pad0), .frame_done(done0)
    );

    eth_mac_tx_fcs_ctrl #(.MIN_LEN(1), .IFG_CYCLES(0), .CNT_W(11)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave),
        .busy(busy1), .pad_active(pad1), .frame_done(done1)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   rdy_mode = 0;
    logic sb_en0   = 1'b1;
    int   xfer0    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference CRC-32 (reflected 0x04C11DB7), one byte at a time.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    task automatic push_frame(input int which, input int len, input logic [7:0] base, input int min_len);
        logic [31:0] c;
        logic [7:0]  b;
        exp_t        e;
        int          total;
        c     = 32'hFFFF_FFFF;
        total = (len < min_len) ? min_len : len;
        for (int i = 0; i < total; i++) begin
            b      = (i < len) ? base + 8'(i) : 8'h00;
            c      = crc_step(c, b);
            e.d    = b;
            e.last = 1'b0;
            e.pad  = (i >= len);
            if (which == 0) q0.push_back(e); else q1.push_back(e);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) begin
            e.d    = c[8*k +: 8];
            e.last = (k == 3);
            e.pad  = 1'b0;
            if (which == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic set_s(input int which, input logic v, input logic [7:0] d, input logic l);
        if (which == 0) begin
            bus0.s_tvalid = v; bus0.s_tdata = d; bus0.s_tlast = l;
        end else begin
            bus1.s_tvalid = v; bus1.s_tdata = d; bus1.s_tlast = l;
        end
    endtask

    task automatic send_frame(input int which, input int len, input logic [7:0] base);
        int  budget;
        logic rdy;
        for (int i = 0; i < len; i++) begin
            set_s(which, 1'b1, base + 8'(i), i == len - 1);
            budget = 0;
            forever begin
                @(negedge clk);
                rdy = (which == 0) ? bus0.s_tready : bus1.s_tready;
                if (rdy) break;
                budget++;
                if (budget > 2000) begin
                    fail_now("s_handshake_timeout");
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        set_s(which, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy0 || busy1) && b < 3000) begin
            @(posedge clk);
            b++;
        end
        if (b >= 3000) fail_now("drain_timeout");
        #1;
    endtask

    task automatic chk_idle0(input string tag);
        chk({tag, "_m_tvalid"},   32'(bus0.m_tvalid), 0);
        chk({tag, "_m_tdata"},    32'(bus0.m_tdata),  0);
        chk({tag, "_m_tlast"},    32'(bus0.m_tlast),  0);
        chk({tag, "_s_tready"},   32'(bus0.s_tready), 0);
        chk({tag, "_busy"},       32'(busy0),         0);
        chk({tag, "_pad_active"}, 32'(pad0),          0);
        chk({tag, "_frame_done"}, 32'(done0),         0);
    endtask

    initial begin
        bus0.m_tready = 1'b1;
        bus1.m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus0.m_tready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Monitor for dut0: scoreboard pop, back-pressure hold and inter-frame gap.
    initial begin
        logic       stall, after_last;
        logic [7:0] hold_d;
        logic       hold_l;
        int         gap;
        exp_t       e;
        stall = 1'b0; after_last = 1'b0; gap = 0; hold_d = 8'h00; hold_l = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0; after_last = 1'b0; gap = 0;
            end else begin
                if (stall && bus0.m_tvalid) begin
                    chk("hold_m_tdata", 32'(bus0.m_tdata), 32'(hold_d));
                    chk("hold_m_tlast", 32'(bus0.m_tlast), 32'(hold_l));
                end
                if (after_last) begin
                    if (bus0.m_tvalid) begin
                        if (sb_en0) chk("ifg_gap_ge_12", 32'(gap >= 12), 1);
                        after_last = 1'b0;
                    end else begin
                        gap++;
                    end
                end
                if (bus0.m_tvalid && bus0.m_tready) begin
                    xfer0++;
                    if (sb_en0) begin
                        if (q0.size() == 0) begin
                            fail_now("dut0_unexpected_byte");
                        end else begin
                            e = q0.pop_front();
                            chk("dut0_m_tdata",     32'(bus0.m_tdata), 32'(e.d));
                            chk("dut0_m_tlast",     32'(bus0.m_tlast), 32'(e.last));
                            chk("dut0_pad_active",  32'(pad0),         32'(e.pad));
                            chk("dut0_frame_done",  32'(done0),        32'(e.last));
                        end
                    end
                    if (bus0.m_tlast) begin
                        after_last = 1'b1;
                        gap        = 0;
                    end
                    stall = 1'b0;
                end else begin
                    stall  = bus0.m_tvalid;
                    hold_d = bus0.m_tdata;
                    hold_l = bus0.m_tlast;
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus1.m_tvalid && bus1.m_tready) begin
                if (q1.size() == 0) begin
                    fail_now("dut1_unexpected_byte");
                end else begin
                    e = q1.pop_front();
                    chk("dut1_m_tdata",    32'(bus1.m_tdata), 32'(e.d));
                    chk("dut1_m_tlast",    32'(bus1.m_tlast), 32'(e.last));
                    chk("dut1_pad_active", 32'(pad1),         32'(e.pad));
                    chk("dut1_frame_done", 32'(done1),        32'(e.last));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int base_x;
        rst = 1'b1;
        set_s(0, 1'b0, 8'h00, 1'b0);
        set_s(1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle0("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 64-byte frame, no padding
        push_frame(0, 64, 8'h00, 60);
        send_frame(0, 64, 8'h00);

        // 10-byte frame padded with 50 zero bytes
        push_frame(0, 10, 8'hA0, 60);
        send_frame(0, 10, 8'hA0);

        // back-to-back identical 60-byte frames: same FCS only if CRC was cleared
        push_frame(0, 60, 8'h10, 60);
        push_frame(0, 60, 8'h10, 60);
        send_frame(0, 60, 8'h10);
        send_frame(0, 60, 8'h10);

        // 61-byte frame, first with steady ready, then with random back-pressure
        push_frame(0, 61, 8'h33, 60);
        send_frame(0, 61, 8'h33);
        drain();
        rdy_mode = 1;
        push_frame(0, 61, 8'h33, 60);
        send_frame(0, 61, 8'h33);
        drain();
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // abort a frame with reset while the second FCS byte is on the bus
        sb_en0 = 1'b0;
        base_x = xfer0;
        send_frame(0, 60, 8'h77);
        b = 0;
        while (xfer0 < base_x + 61 && b < 500) begin
            @(posedge clk);
            b++;
        end
        if (b >= 500) fail_now("abort_wait_timeout");
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk_idle0("midframe_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_busy", 32'(busy0), 0);
        @(posedge clk);
        #1;
        sb_en0 = 1'b1;
        push_frame(0, 60, 8'h55, 60);
        send_frame(0, 60, 8'h55);

        // MIN_LEN=1, no IFG: 1-byte frame then 3-byte frame
        push_frame(1, 1, 8'h5A, 1);
        send_frame(1, 1, 8'h5A);
        push_frame(1, 3, 8'h01, 1);
        send_frame(1, 3, 8'h01);

        drain();
        chk("q0_left_over", 32'(q0.size()), 0);
        chk("q1_left_over", 32'(q1.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
